accum_drain: RTL
================

// Module: accum_drain
// PURPOSE
//  Reader for the multiply/accumulate cell grid: snapshots all NUM_ROWS*NUM_COLS
//  32-bit accumulator outputs on request, then streams them out one per beat over
//  a valid/ready interface. Sits beside the grid top and drains results to the host path.
// PARAMETERS
//  NUM_ROWS  4   grid rows
//  NUM_COLS  16  grid columns; N = NUM_ROWS*NUM_COLS result words
//  DATA_W    32  width of each accumulator result
// PORTS
//  i_clk      in   1                     clock; all logic on rising edge
//  i_reset_n  in   1                     asynchronous active-low reset
//  i_start    in   1                     drain request pulse
//  i_sum      in   N*DATA_W              grid results; word k = row*NUM_COLS+col at [k*DATA_W +: DATA_W]
//  o_busy     out  1                     high from capture until o_done
//  o_valid    out  1                     output beat valid
//  i_ready    in   1                     downstream accepts beat
//  o_data     out  DATA_W                beat payload
//  o_index    out  $clog2(N)+1           beat index
//  o_last     out  1                     final beat of drain
//  o_done     out  1                     one-cycle pulse after final beat accepted
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; o_busy, o_valid, o_last, o_done = 0;
//    o_data, o_index = 0; shadow bank contents don't-care.
//  - FSM IDLE -> SEND -> DONE -> IDLE.
//  - IDLE: i_start=1 captures all N words of i_sum into shadow bank at that edge; idx=0;
//    go SEND. o_valid first high the cycle after i_start (latency 1).
//  - SEND: o_valid=1, o_data=shadow[idx], o_index=idx, o_last=(idx==last beat).
//    Transfer = o_valid & i_ready; on transfer idx++ ; on transfer of last beat go DONE.
//    While o_valid & !i_ready: o_data/o_index/o_last held stable; no drop, no duplicate.
//    Full throughput: i_ready held high gives one beat per cycle, no bubbles.
//  - DONE: o_valid=0, o_done=1 for exactly one cycle, o_busy=0 same cycle; -> IDLE.
//  - o_busy=1 in SEND; i_start in SEND or DONE ignored (no re-capture, no restart).
//  - i_sum changes after capture have no effect on the stream.
//  - Order strictly row-major: index 0 = row0/col0, index NUM_COLS = row1/col0.
//  - i_ready while o_valid=0 is ignored.
//  - Reset mid-drain: immediate return to IDLE values above; next i_start drains from index 0.
// CONFIGURATION
//  DRAIN_CHECKSUM_EN defined: after beat N-1, one extra beat index N carrying sum of all
//    N captured words mod 2^DATA_W; o_last moves to this checksum beat; same handshake rules.
//  Not defined: exactly N beats, o_last on index N-1, no checksum logic instantiated.
// TESTING
//  1 Assert i_reset_n=0 mid-cycle -> all outputs 0 without waiting for clock edge.
//  2 i_sum word k = 0x1000+k, pulse i_start, i_ready=1 -> 64 consecutive beats, index 0..63,
//    data 0x1000..0x103F, o_last only on index 63, o_done one cycle after, o_busy low then.
//  3 As 2 with i_ready toggling 1,0,1,0 and random stalls -> data/index stable while stalled,
//    64 unique beats in order, none lost or repeated.
//  4 After i_start, overwrite all i_sum with 0xDEADBEEF and pulse i_start at beat 10 ->
//    stream still 0x1000+k, no restart, single o_done.
//  5 Reset at beat 20, release, i_sum word k = k, i_start -> fresh drain beginning index 0, data 0.
//  6 DRAIN_CHECKSUM_EN, stimulus of 2 -> 65 beats, index 64 data 0x000407E0 with o_last;
//    without macro index 63 carries o_last and no 65th beat.

Source files
------------

// File: rtl/accum_drain.sv
// accum_drain: snapshots the N-word accumulator grid on i_start and streams it out over valid/ready.
// Define DRAIN_CHECKSUM_EN to append a modular-sum checksum beat at index N.
module accum_drain #(
   parameter int NUM_ROWS = 4,
   parameter int NUM_COLS = 16,
   parameter int DATA_W   = 32,
   localparam int N  = NUM_ROWS * NUM_COLS,
   localparam int IW = $clog2(N) + 1
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_start,
   input  logic [N*DATA_W-1:0] i_sum,
   output logic                o_busy,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [DATA_W-1:0]   o_data,
   output logic [IW-1:0]       o_index,
   output logic                o_last,
   output logic                o_done
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
`ifdef DRAIN_CHECKSUM_EN
   localparam logic [IW-1:0] LAST = IW'(N);
`else
   localparam logic [IW-1:0] LAST = IW'(N - 1);
`endif
   logic [1:0]        state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] shadow_q [N];
   logic [DATA_W-1:0] word;
   logic [DATA_W-1:0] beat_data;
   logic              cap, xfer, send;
   assign send = state_q == SEND;
   assign cap  = state_q == IDLE && i_start;
   assign xfer = send && i_ready;
   assign word = shadow_q[idx_q[IW-2:0]];
   always_comb begin
      state_d = cap ? SEND : (xfer && idx_q == LAST) ? DONE : (state_q == DONE) ? IDLE : state_q;
      idx_d   = (state_q == IDLE) ? '0 : xfer ? idx_q + 1'b1 : idx_q;
   end
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end
   // Shadow bank needs no reset: it is always rewritten before it is read.
   always_ff @(posedge i_clk) begin
      if (cap) begin
         for (int k = 0; k < N; k++) shadow_q[k] <= i_sum[k*DATA_W +: DATA_W];
      end
   end
`ifdef DRAIN_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
   // Running sum over the words as they leave; complete by the time idx reaches N.
   always_comb csum_d = cap ? '0 : (xfer && idx_q != IW'(N)) ? csum_q + word : csum_q;
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) csum_q <= '0;
      else            csum_q <= csum_d;
   end
   assign beat_data = (idx_q == IW'(N)) ? csum_q : word;
`else
   assign beat_data = word;
`endif
   always_comb begin
      o_busy  = send;
      o_valid = send;
      o_data  = send ? beat_data : '0;
      o_index = send ? idx_q : '0;
      o_last  = send && idx_q == LAST;
      o_done  = state_q == DONE;
   end
endmodule
